cs_result_collector: RTL

CS_RESULT_COLLECTOR -- requirements
Module: cs_result_collector

---
 rtl/cs_pkg.sv | 30 +++
 rtl/cs_result_collector_if.sv | 32 +++
 rtl/cs_sync_fifo.sv | 84 ++++++++
 rtl/cs_result_collector.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// cs_pkg: shared constants and types for the computational-system result path.
//   X_W    - input sample width of the computational system
//   Y_W    - result word width
//   WARMUP - number of y_en slots discarded while the window fills
//   cs_state_e - collector state encoding
//   sat_inc16  - saturating 16-bit increment used by the result counter
package cs_pkg;

  localparam int X_W    = 8;
  localparam int Y_W    = 10;
  localparam int WARMUP = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } cs_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cs_result_collector_if.sv
// cs_result_collector_if: result input slot and output stream of the collector.
//   y_in/y_en            - result word and its slot qualifier from the system
//   out_data/out_valid   - head-of-FIFO result offered downstream
//   out_ready            - downstream acceptance
// Modports: master = collector side, slave = environment side.
interface cs_result_collector_if
  import cs_pkg::*;
#(
  parameter int Y_W = cs_pkg::Y_W
);
  logic [Y_W-1:0] y_in;
  logic           y_en;
  logic [Y_W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;

  modport master (
    input  y_in,
    input  y_en,
    input  out_ready,
    output out_data,
    output out_valid
  );

  modport slave (
    output y_in,
    output y_en,
    output out_ready,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/cs_sync_fifo.sv
// cs_sync_fifo: single-clock FIFO with registered storage and head read.
//   clk   - clock
//   clr   - synchronous clear (empties FIFO, zeroes storage)
//   push  - write wdata when not full, or when full with a same-cycle pop
//   pop   - advance head when not empty
//   wdata - write word
//   rdata - head word (storage read, no fall-through from wdata)
//   full, empty, count - occupancy status; count is log2(DEPTH)+1 bits
module cs_sync_fifo
  import cs_pkg::*;
#(
  parameter int WIDTH = cs_pkg::Y_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == {CW{1'b0}});
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  // A pop frees the slot in the same cycle, so a full FIFO can still take a push then.
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok_s) begin
      wr_d = wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok_s) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wr_q] <= wdata;
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cs_result_collector.sv
// cs_result_collector: drops the warm-up results of the computational system,
// buffers the rest in a FIFO and keeps running min/max/count statistics.
//   clk, reset  - clock; synchronous active-high reset
//   bus         - y_in/y_en slot input and out_data/out_valid/out_ready stream
//   flush       - synchronous restart, identical in effect to reset
//   overflow    - sticky: a result was dropped on a full FIFO
//   y_min/y_max - extremes of accepted results since reset/flush
//   res_cnt     - accepted-result count, saturating
module cs_result_collector
  import cs_pkg::*;
#(
  parameter int Y_W    = cs_pkg::Y_W,
  parameter int DEPTH  = 8,
  parameter int WARMUP = cs_pkg::WARMUP
) (
  input  logic                  clk,
  input  logic                  reset,
  cs_result_collector_if.master bus,
  input  logic                  flush,
  output logic                  overflow,
  output logic [Y_W-1:0]        y_min,
  output logic [Y_W-1:0]        y_max,
  output logic [15:0]           res_cnt
);
  localparam int WCW = $clog2(WARMUP + 1);
  localparam int CW  = $clog2(DEPTH) + 1;

  cs_state_e      state_q, state_d;
  logic [WCW-1:0] warm_q, warm_d;
  logic           ovf_q, ovf_d;
  logic [Y_W-1:0] min_q, min_d;
  logic [Y_W-1:0] max_q, max_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           seen_q, seen_d;

  logic           push_req_s;
  logic           pop_s;
  logic           push_acc_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [CW-1:0]  fifo_count_s;

  // flush outranks both sides of the FIFO handshake.
  assign pop_s      = (fifo_count_s != {CW{1'b0}}) & bus.out_ready & ~flush;
  assign push_acc_s = push_req_s & (~fifo_full_s | pop_s);

  cs_sync_fifo #(
    .WIDTH (Y_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (reset | flush),
    .push  (push_req_s),
    .pop   (pop_s),
    .wdata (bus.y_in),
    .rdata (bus.out_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign bus.out_valid = ~fifo_empty_s;
  assign overflow      = ovf_q;
  assign y_min         = min_q;
  assign y_max         = max_q;
  assign res_cnt       = cnt_q;

  // FSM next state: warm-up slot counting and push request generation.
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    push_req_s = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      warm_d  = {WCW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.y_en) begin
            // This slot is warm-up slot 1.
            warm_d  = WCW'(1);
            state_d = (WARMUP <= 1) ? ST_RUN : ST_WARMUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WARMUP: begin
          if (bus.y_en) begin
            warm_d = warm_q + WCW'(1);
            if (warm_d == WCW'(WARMUP)) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_WARMUP;
            end
          end else begin
            state_d = ST_WARMUP;
          end
        end
        ST_RUN: begin
          push_req_s = bus.y_en;
          state_d    = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          warm_d  = {WCW{1'b0}};
        end
      endcase
    end
  end

  // Statistics and sticky overflow next state.
  always_comb begin
    ovf_d  = ovf_q;
    min_d  = min_q;
    max_d  = max_q;
    cnt_d  = cnt_q;
    seen_d = seen_q;
    if (flush) begin
      ovf_d  = 1'b0;
      min_d  = {Y_W{1'b0}};
      max_d  = {Y_W{1'b0}};
      cnt_d  = 16'd0;
      seen_d = 1'b0;
    end else if (push_acc_s) begin
      // First accepted result seeds both extremes.
      min_d  = (!seen_q || bus.y_in < min_q) ? bus.y_in : min_q;
      max_d  = (!seen_q || bus.y_in > max_q) ? bus.y_in : max_q;
      cnt_d  = sat_inc16(cnt_q);
      seen_d = 1'b1;
    end else if (push_req_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      warm_q  <= {WCW{1'b0}};
      ovf_q   <= 1'b0;
      min_q   <= {Y_W{1'b0}};
      max_q   <= {Y_W{1'b0}};
      cnt_q   <= 16'd0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      ovf_q   <= ovf_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
    end
  end
endmodule
